// File: rtl/trafficlight_pkg.sv
// trafficlight_pkg: phase encodings, lamp patterns and default durations for the intersection sequencer.
package trafficlight_pkg;
  typedef enum logic [2:0] {G1 = 3'd0, Y1 = 3'd1, AR1 = 3'd2, G2 = 3'd3, Y2 = 3'd4, AR2 = 3'd5, EMG = 3'd6} state_t;
  localparam int G_TIME_DEF = 5;
  localparam int Y_TIME_DEF = 2;
  localparam int AR_TIME_DEF = 1;
  // Lamp vectors are {r1,y1,g1,r2,y2,g2}
  localparam logic [5:0] LAMP_G1 = 6'b001100;
  localparam logic [5:0] LAMP_Y1 = 6'b010100;
  localparam logic [5:0] LAMP_G2 = 6'b100001;
  localparam logic [5:0] LAMP_Y2 = 6'b100010;
  localparam logic [5:0] LAMP_RR = 6'b100100;
  function automatic logic [5:0] lamps_of(input state_t s);
    return s == G1 ? LAMP_G1 : s == Y1 ? LAMP_Y1 : s == G2 ? LAMP_G2 : s == Y2 ? LAMP_Y2 : LAMP_RR;
  endfunction
  function automatic state_t next_of(input state_t s);
    return s == G1 ? Y1 : s == Y1 ? AR1 : s == AR1 ? G2 : s == G2 ? Y2 : s == Y2 ? AR2 : G1;
  endfunction
endpackage

// File: rtl/trafficlight_sequencer.sv
// trafficlight_sequencer: two-road phase FSM driving the shared countdown counter and lamps.
module trafficlight_sequencer
  import trafficlight_pkg::*;
#(
  parameter int G_TIME = G_TIME_DEF,
  parameter int Y_TIME = Y_TIME_DEF,
  parameter int AR_TIME = AR_TIME_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ihand,
  input  logic       istep,
  input  logic       ichong,
  input  logic       cnt_done,
  output logic       cnt_start,
  output logic [2:0] cnt_goal,
  output logic       cnt_enable,
  output logic       r1,
  output logic       y1,
  output logic       g1,
  output logic       r2,
  output logic       y2,
  output logic       g2,
  output logic [2:0] phase
);
  state_t state_q, state_d;
  logic first_q, first_d, second_q, istep_q, green, adv;
  logic [5:0] lamps_q;
  logic [2:0] phase_q, goal;
  always_comb begin
    green = state_q == G1 || state_q == G2;
    // done is stale for two cycles after entry: the counter clears it one edge after the load pulse
    adv = green && ihand ? istep & ~istep_q : ~first_q & ~second_q & cnt_done;
    state_d = ichong ? EMG : state_q == EMG ? AR2 : adv ? next_of(state_q) : state_q;
    first_d = state_d != state_q;
    goal = state_q == EMG ? 3'd0 : green ? 3'(G_TIME) : (state_q == Y1 || state_q == Y2) ? 3'(Y_TIME) : 3'(AR_TIME);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= AR2;
      first_q <= 1'b1;
      second_q <= 1'b0;
      istep_q <= 1'b0;
      lamps_q <= lamps_of(AR2);
      phase_q <= 3'(AR2);
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      second_q <= first_q;
      istep_q <= istep;
      lamps_q <= lamps_of(state_d);
      phase_q <= 3'(state_d);
    end
  end
  assign cnt_enable = ~rst & (state_q != EMG);
  assign cnt_start = cnt_enable & first_q;
  assign cnt_goal = rst ? 3'd0 : goal;
  assign {r1, y1, g1, r2, y2, g2} = lamps_q;
  assign phase = phase_q;
endmodule

// File: tb/tb_trafficlight_sequencer.sv
// tb_trafficlight_sequencer: directed stimulus with a phase-change scoreboard and a simple counter model.
module tb_trafficlight_sequencer;
  logic clk = 1'b0, rst = 1'b1, ihand = 1'b0, istep = 1'b0, ichong = 1'b0, force_done = 1'b0;
  logic cnt_done, cnt_start, cnt_enable, r1, y1, g1, r2, y2, g2, mdone = 1'b0, mon_en = 1'b0;
  logic [2:0] cnt_goal, phase, last = 3'd5;
  logic [5:0] lamps;
  int cnt = 0, tests = 0, fails = 0, starts = 0;
  typedef struct {logic [2:0] ph; logic [5:0] lamps; logic [2:0] goal;} exp_t;
  exp_t q[$];
  always #5 clk = ~clk;
  assign lamps = {r1, y1, g1, r2, y2, g2};
  assign cnt_done = mdone | force_done;
  trafficlight_sequencer dut (.clk(clk), .rst(rst), .ihand(ihand), .istep(istep), .ichong(ichong),
    .cnt_done(cnt_done), .cnt_start(cnt_start), .cnt_goal(cnt_goal), .cnt_enable(cnt_enable),
    .r1(r1), .y1(y1), .g1(g1), .r2(r2), .y2(y2), .g2(g2), .phase(phase));
  always @(posedge clk) begin
    if (rst || !cnt_enable) begin
      cnt <= 0;
      mdone <= 1'b0;
    end else if (cnt_start) begin
      cnt <= 3;
      mdone <= 1'b0;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) mdone <= 1'b1;
    end
  end
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic push(input logic [2:0] ph, input logic [5:0] l, input logic [2:0] g);
    exp_t e;
    e.ph = ph; e.lamps = l; e.goal = g;
    q.push_back(e);
  endtask
  task automatic wait_phase(input logic [2:0] p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phase !== p && n < 300);
    chk("wait_phase", {5'd0, phase}, {5'd0, p});
  endtask
  initial forever begin
    @(negedge clk);
    #2;
    if (mon_en) begin
      if (phase !== last) begin
        exp_t e;
        chk("starts_per_state", 8'(starts), (last == 3'd6) ? 8'd0 : 8'd1);
        starts = int'(cnt_start);
        if (q.size() == 0) begin
          chk("unexpected_phase", {5'd0, phase}, 8'hff);
        end else begin
          e = q.pop_front();
          chk("mon_phase", {5'd0, phase}, {5'd0, e.ph});
          chk("mon_lamps", {2'd0, lamps}, {2'd0, e.lamps});
          chk("mon_goal", {5'd0, cnt_goal}, {5'd0, e.goal});
          chk("mon_entry", {6'd0, cnt_start, cnt_enable}, (e.ph == 3'd6) ? 8'd0 : 8'd3);
        end
        last = phase;
      end else begin
        starts += int'(cnt_start);
      end
    end
  end
  initial begin
    push(3'd0, 6'b001100, 3'd5); push(3'd1, 6'b010100, 3'd2); push(3'd2, 6'b100100, 3'd1); push(3'd3, 6'b100001, 3'd5);
    push(3'd4, 6'b100010, 3'd2); push(3'd5, 6'b100100, 3'd1); push(3'd0, 6'b001100, 3'd5); push(3'd1, 6'b010100, 3'd2);
    push(3'd6, 6'b100100, 3'd0); push(3'd5, 6'b100100, 3'd1); push(3'd0, 6'b001100, 3'd5);
    push(3'd6, 6'b100100, 3'd0); push(3'd5, 6'b100100, 3'd1); push(3'd0, 6'b001100, 3'd5);
    push(3'd1, 6'b010100, 3'd2); push(3'd2, 6'b100100, 3'd1); push(3'd3, 6'b100001, 3'd5);
    push(3'd5, 6'b100100, 3'd1); push(3'd0, 6'b001100, 3'd5);
    repeat (3) @(negedge clk);
    chk("rst_phase", {5'd0, phase}, 8'd5);
    chk("rst_lamps", {2'd0, lamps}, 8'b00100100);
    chk("rst_ctl", {3'd0, cnt_start, cnt_enable, cnt_goal}, 8'd0);
    rst = 1'b0;
    #1;
    chk("rel_ctl", {3'd0, cnt_start, cnt_enable, cnt_goal}, 8'b00011001);
    mon_en = 1'b1;
    wait_phase(3'd0);
    force_done = 1'b1;
    wait_phase(3'd1);
    @(negedge clk);
    chk("stale_y1_c2", {5'd0, phase}, 8'd1);
    @(negedge clk);
    chk("stale_y1_c3", {5'd0, phase}, 8'd1);
    force_done = 1'b0;
    wait_phase(3'd3);
    ihand = 1'b1;
    force_done = 1'b1;
    repeat (50) @(negedge clk);
    chk("manual_hold_g2", {5'd0, phase}, 8'd3);
    istep = 1'b1;
    @(negedge clk);
    chk("manual_step_y2", {5'd0, phase}, 8'd4);
    force_done = 1'b0;
    istep = 1'b0;
    @(negedge clk);
    istep = 1'b1;
    wait_phase(3'd0);
    force_done = 1'b1;
    repeat (20) @(negedge clk);
    chk("manual_hold_g1", {5'd0, phase}, 8'd0);
    ihand = 1'b0;
    @(negedge clk);
    chk("hand_release_y1", {5'd0, phase}, 8'd1);
    force_done = 1'b0;
    istep = 1'b0;
    @(negedge clk);
    ichong = 1'b1;
    @(negedge clk);
    #1;
    chk("emg_phase", {5'd0, phase}, 8'd6);
    chk("emg_ctl", {6'd0, cnt_start, cnt_enable}, 8'd0);
    repeat (4) @(negedge clk);
    chk("emg_hold", {5'd0, phase}, 8'd6);
    ichong = 1'b0;
    @(negedge clk);
    #1;
    chk("emg_exit_phase", {5'd0, phase}, 8'd5);
    chk("emg_exit_ctl", {4'd0, cnt_start, cnt_goal}, 8'b00001001);
    wait_phase(3'd0);
    #1;
    chk("simul_start", {7'd0, cnt_start}, 8'd1);
    ihand = 1'b1; ichong = 1'b1; istep = 1'b1; force_done = 1'b1;
    @(negedge clk);
    #1;
    chk("simul_emg", {5'd0, phase}, 8'd6);
    chk("simul_enable", {7'd0, cnt_enable}, 8'd0);
    ihand = 1'b0; ichong = 1'b0; istep = 1'b0; force_done = 1'b0;
    wait_phase(3'd0);
    wait_phase(3'd3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_ctl", {3'd0, cnt_start, cnt_enable, cnt_goal}, 8'd0);
    @(negedge clk);
    chk("midrst_phase", {5'd0, phase}, 8'd5);
    chk("midrst_lamps", {2'd0, lamps}, 8'b00100100);
    rst = 1'b0;
    #1;
    chk("midrst_restart", {7'd0, cnt_start}, 8'd1);
    wait_phase(3'd0);
    repeat (3) @(negedge clk);
    chk("queue_empty", 8'(q.size()), 8'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
